gbm_path_engine: RTL and testbench

- Multi-path, multi-step geometric Brownian motion (GBM) price engine for the QMC-LSM datapath.
- After a `start`, consumes a stream of normal deviates `z` and advances N_PATHS interleaved price paths for N_STEPS Euler steps:
  - update: S ← S + S·(drift + vol·z)
- Streams every intermediate price, tagged with path and step indices, to the downstream regression/LSM stage.
- Generalises the single-shot GBM step unit:
  - on-chip per-path state;
  - step/path sequencing;
  - price floor and saturation tracking;
  - elastic back-pressure.

---
 rtl/gbm_path_engine_if.sv | 56 +++++
 rtl/gbm_path_engine.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_gbm_path_engine.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gbm_path_engine_if.sv
// ---------------------------------------------------------------------------
// gbm_path_engine_if
//   Bundles the control, configuration and both streaming handshakes of the
//   GBM path engine.
//
//   Signals
//     start, cfg_s0, cfg_drift, cfg_vol : run start and per-run parameters
//     valid_in / ready_out / z          : inbound normal-deviate stream
//     valid_out / ready_in / S_next,
//     path_idx, step_idx, last          : outbound price stream with tags
//     busy, done, sat_seen              : run status
//
//   Modports
//     master : the environment (drives config, z, ready_in)
//     slave  : the engine
// ---------------------------------------------------------------------------
interface gbm_path_engine_if #(
  parameter int WIDTH   = 32,
  parameter int N_PATHS = 8,
  parameter int N_STEPS = 16
);
  localparam int PW = (N_PATHS > 1) ? $clog2(N_PATHS) : 1;
  localparam int SW = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

  logic             start;
  logic [WIDTH-1:0] cfg_s0;
  logic [WIDTH-1:0] cfg_drift;
  logic [WIDTH-1:0] cfg_vol;

  logic             valid_in;
  logic             ready_out;
  logic [WIDTH-1:0] z;

  logic             valid_out;
  logic             ready_in;
  logic [WIDTH-1:0] S_next;
  logic [PW-1:0]    path_idx;
  logic [SW-1:0]    step_idx;
  logic             last;

  logic             busy;
  logic             done;
  logic             sat_seen;

  modport master (
    output start, cfg_s0, cfg_drift, cfg_vol, valid_in, z, ready_in,
    input  ready_out, valid_out, S_next, path_idx, step_idx, last,
           busy, done, sat_seen
  );

  modport slave (
    input  start, cfg_s0, cfg_drift, cfg_vol, valid_in, z, ready_in,
    output ready_out, valid_out, S_next, path_idx, step_idx, last,
           busy, done, sat_seen
  );
endinterface

// File: rtl/gbm_path_engine.sv
// ---------------------------------------------------------------------------
// gbm_path_engine
//   Advances N_PATHS interleaved geometric-Brownian-motion price paths for
//   N_STEPS Euler steps, S <- S + S*(drift + vol*z), consuming one normal
//   deviate per beat and streaming every intermediate price with its
//   (path, step) tag.
//
//   Ports
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     bus    : gbm_path_engine_if.slave (config, z stream, price stream,
//              busy/done/sat_seen status)
//
//   Pipeline (all stages freeze together while valid_out && !ready_in)
//     S1 : f  = sat(drift + round(vol*z))
//     S2 : p  = round(S[path]*f), S[path] read from path storage
//     S3 : S' = clamp(S[path] + p), written back and presented on S_next
// ---------------------------------------------------------------------------
module gbm_path_engine #(
  parameter int WIDTH   = 32,
  parameter int QFRAC   = 16,
  parameter int N_PATHS = 8,
  parameter int N_STEPS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gbm_path_engine_if.slave     bus
);

  localparam int PW = (N_PATHS > 1) ? $clog2(N_PATHS) : 1;
  localparam int SW = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

  localparam logic [PW-1:0] PATH_LAST = PW'(N_PATHS - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(N_STEPS - 1);

  localparam logic signed [WIDTH-1:0] MAXW = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINW = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic signed [2*WIDTH-1:0] WMAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] WMIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [2*WIDTH-1:0] HALF =
    {{(2*WIDTH-QFRAC){1'b0}}, 1'b1, {(QFRAC-1){1'b0}}};

  // Write-back happens one beat after the read; at least four interleaved
  // paths keep a path's next read well clear of its pending write.
  generate
    if (N_PATHS < 4) begin : g_bad_paths
      $error("gbm_path_engine: N_PATHS must be >= 4");
    end
    if (N_STEPS < 1) begin : g_bad_steps
      $error("gbm_path_engine: N_STEPS must be >= 1");
    end
  endgenerate

  // Rounded fixed-point rescale of a full-width product.
  // Bit WIDTH of the result flags saturation.
  function automatic logic [WIDTH:0] round_sat(input logic signed [2*WIDTH-1:0] prod);
    logic signed [2*WIDTH-1:0] r;
    r = (prod + HALF) >>> QFRAC;
    if (r > WMAX) begin
      return {1'b1, MAXW};
    end else if (r < WMIN) begin
      return {1'b1, MINW};
    end
    return {1'b0, r[WIDTH-1:0]};
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state;

  // Run configuration and per-path price storage
  logic signed [WIDTH-1:0] drift_r;
  logic signed [WIDTH-1:0] vol_r;
  logic signed [WIDTH-1:0] store [N_PATHS];

  // Sequencing counters for the next accepted z
  logic [PW-1:0] path_cnt;
  logic [SW-1:0] step_cnt;

  // Stage 1
  logic                    v1;
  logic                    last1;
  logic                    sat1;
  logic [PW-1:0]           path1;
  logic [SW-1:0]           step1;
  logic signed [WIDTH-1:0] f1;

  // Stage 2
  logic                    v2;
  logic                    last2;
  logic                    sat2;
  logic [PW-1:0]           path2;
  logic [SW-1:0]           step2;
  logic signed [WIDTH-1:0] s2;
  logic signed [WIDTH-1:0] p2;

  // Stage 3 (output registers)
  logic                    v3;
  logic                    last3;
  logic [PW-1:0]           path3;
  logic [SW-1:0]           step3;
  logic signed [WIDTH-1:0] s3;

  logic busy_r;
  logic done_r;
  logic sat_seen_r;

  // Handshake / control
  logic adv;
  logic ready_out;
  logic in_hs;
  logic out_hs;
  logic start_acc;
  logic in_last;

  // Stage combinational results
  logic signed [2*WIDTH-1:0] prod1;
  logic        [WIDTH:0]     vz_rs;
  logic signed [WIDTH:0]     fsum;
  logic signed [WIDTH-1:0]   f_next;
  logic                      sat_f;

  logic signed [WIDTH-1:0]   s_rd;
  logic signed [2*WIDTH-1:0] prod2;
  logic        [WIDTH:0]     p_rs;

  logic signed [WIDTH:0]     sum3;
  logic signed [WIDTH-1:0]   s3_next;
  logic                      clamp3;

  always_comb begin
    adv       = bus.ready_in || !v3;
    ready_out = (state == RUN) && adv;
    in_hs     = bus.valid_in && ready_out;
    out_hs    = v3 && bus.ready_in;
    // The cycle carrying done is already IDLE; a start there is held off
    // so the environment sees done before a new run begins.
    start_acc = bus.start && (state == IDLE) && !done_r;
    in_last   = (path_cnt == PATH_LAST) && (step_cnt == STEP_LAST);
  end

  // S1: f = drift + round(vol*z), saturating both the product and the sum
  always_comb begin
    prod1  = (2*WIDTH)'(vol_r) * (2*WIDTH)'($signed(bus.z));
    vz_rs  = round_sat(prod1);
    fsum   = {drift_r[WIDTH-1], drift_r} + {vz_rs[WIDTH-1], vz_rs[WIDTH-1:0]};
    f_next = fsum[WIDTH-1:0];
    sat_f  = vz_rs[WIDTH];
    if (fsum[WIDTH] != fsum[WIDTH-1]) begin
      f_next = fsum[WIDTH] ? MINW : MAXW;
      sat_f  = 1'b1;
    end
  end

  // S2: p = round(S[path]*f)
  always_comb begin
    s_rd  = store[path1];
    prod2 = (2*WIDTH)'(s_rd) * (2*WIDTH)'(f1);
    p_rs  = round_sat(prod2);
  end

  // S3: S' = S + p with price floor at zero and ceiling at signed max
  always_comb begin
    sum3    = {s2[WIDTH-1], s2} + {p2[WIDTH-1], p2};
    s3_next = sum3[WIDTH-1:0];
    clamp3  = 1'b0;
    if (sum3[WIDTH]) begin
      s3_next = '0;
      clamp3  = 1'b1;
    end else if (sum3[WIDTH-1]) begin
      s3_next = MAXW;
      clamp3  = 1'b1;
    end
  end

  // Datapath: configuration, path storage and the three pipeline stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drift_r <= '0;
      vol_r   <= '0;
      store   <= '{default: '0};
      v1      <= 1'b0;
      last1   <= 1'b0;
      sat1    <= 1'b0;
      path1   <= '0;
      step1   <= '0;
      f1      <= '0;
      v2      <= 1'b0;
      last2   <= 1'b0;
      sat2    <= 1'b0;
      path2   <= '0;
      step2   <= '0;
      s2      <= '0;
      p2      <= '0;
      v3      <= 1'b0;
      last3   <= 1'b0;
      path3   <= '0;
      step3   <= '0;
      s3      <= '0;
    end else begin
      if (start_acc) begin
        drift_r <= $signed(bus.cfg_drift);
        vol_r   <= $signed(bus.cfg_vol);
        store   <= '{default: $signed(bus.cfg_s0)};
      end else if (adv && v2) begin
        store[path2] <= s3_next;
      end

      if (adv) begin
        v1 <= in_hs;
        if (in_hs) begin
          last1 <= in_last;
          sat1  <= sat_f;
          path1 <= path_cnt;
          step1 <= step_cnt;
          f1    <= f_next;
        end

        v2 <= v1;
        if (v1) begin
          last2 <= last1;
          sat2  <= sat1 | p_rs[WIDTH];
          path2 <= path1;
          step2 <= step1;
          s2    <= s_rd;
          p2    <= p_rs[WIDTH-1:0];
        end

        // Output tags only move with a real beat so bubbles leave the last
        // presented values in place.
        v3 <= v2;
        if (v2) begin
          last3 <= last2;
          path3 <= path2;
          step3 <= step2;
          s3    <= s3_next;
        end
      end
    end
  end

  // Control FSM with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      path_cnt   <= '0;
      step_cnt   <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      sat_seen_r <= 1'b0;
    end else begin
      done_r <= 1'b0;

      if (adv && v2 && (sat2 || clamp3)) begin
        sat_seen_r <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start_acc) begin
            state      <= RUN;
            busy_r     <= 1'b1;
            path_cnt   <= '0;
            step_cnt   <= '0;
            sat_seen_r <= 1'b0;
          end
        end

        RUN: begin
          if (in_hs) begin
            if (path_cnt == PATH_LAST) begin
              path_cnt <= '0;
              if (step_cnt == STEP_LAST) begin
                state <= DRAIN;
              end else begin
                step_cnt <= step_cnt + 1'b1;
              end
            end else begin
              path_cnt <= path_cnt + 1'b1;
            end
          end
        end

        DRAIN: begin
          if (out_hs && last3) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_out = ready_out;
  assign bus.valid_out = v3;
  assign bus.S_next    = s3;
  assign bus.path_idx  = path3;
  assign bus.step_idx  = step3;
  assign bus.last      = last3;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.sat_seen  = sat_seen_r;

endmodule

// File: tb/tb_gbm_path_engine.sv
// ---------------------------------------------------------------------------
// tb_gbm_path_engine
//   Directed bench for gbm_path_engine with N_PATHS=4, N_STEPS=2.
//   Inputs change 1 ns after the rising edge; outputs and handshakes are
//   sampled on the falling edge. A reference model with 64-bit arithmetic
//   predicts every beat; hand-computed constants pin the directed cases.
// ---------------------------------------------------------------------------
module tb_gbm_path_engine;

  localparam int W  = 32;
  localparam int NP = 4;
  localparam int NS = 2;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk;
  logic rst_n;

  gbm_path_engine_if #(.WIDTH(W), .N_PATHS(NP), .N_STEPS(NS)) bus ();

  gbm_path_engine #(
    .WIDTH  (W),
    .QFRAC  (16),
    .N_PATHS(NP),
    .N_STEPS(NS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint s;
    int     p;
    int     st;
    bit     l;
  } beat_t;

  beat_t  exp_q[$];
  longint got_s[$];
  longint m_s [NP];
  int     m_path;
  int     m_step;
  bit     m_sat;
  longint c_drift;
  longint c_vol;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_in;
  int n_out;
  int last_hs_cyc;
  int done_cyc;
  int first_in_cyc;
  int first_out_cyc;
  bit prev_stall;
  bit arm_start = 1'b0;
  logic [W-1:0] hold_s;
  logic [3:0]   hold_tag;
  int zv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic longint clip(input longint v);
    if (v > SMAX) begin
      m_sat = 1'b1;
      return SMAX;
    end
    if (v < SMIN) begin
      m_sat = 1'b1;
      return SMIN;
    end
    return v;
  endfunction

  function automatic longint rnd(input longint prod);
    return (prod + 64'sd32768) >>> 16;
  endfunction

  task automatic model_push();
    longint f;
    longint pp;
    longint ns;
    beat_t  b;
    f  = clip(c_drift + clip(rnd(c_vol * longint'(zv))));
    pp = clip(rnd(m_s[m_path] * f));
    ns = m_s[m_path] + pp;
    if (ns < 0) begin
      ns    = 0;
      m_sat = 1'b1;
    end else if (ns > SMAX) begin
      ns    = SMAX;
      m_sat = 1'b1;
    end
    m_s[m_path] = ns;
    b.s  = ns;
    b.p  = m_path;
    b.st = m_step;
    b.l  = (m_path == NP-1) && (m_step == NS-1);
    exp_q.push_back(b);
    if (m_path == NP-1) begin
      m_path = 0;
      m_step++;
    end else begin
      m_path++;
    end
  endtask

  // One clock: sample at the falling edge, then return 1 ns after the rise.
  task automatic tick();
    beat_t b;
    @(negedge clk);
    if (prev_stall) begin
      chk("stall_valid", 64'(bus.valid_out), 64'(1));
      chk("stall_s", 64'(bus.S_next), 64'(hold_s));
      chk("stall_tag", 64'({bus.path_idx, bus.step_idx, bus.last}), 64'(hold_tag));
    end
    prev_stall = bus.valid_out && !bus.ready_in;
    if (prev_stall) begin
      hold_s   = bus.S_next;
      hold_tag = {bus.path_idx, bus.step_idx, bus.last};
      chk("stall_ready_out", 64'(bus.ready_out), 64'(0));
    end
    if (bus.valid_in && bus.ready_out) begin
      if (first_in_cyc < 0) first_in_cyc = cyc;
      n_in++;
      model_push();
    end
    if (bus.valid_out && bus.ready_in) begin
      if (first_out_cyc < 0) first_out_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 64'(exp_q.size()), 64'(1));
      end else begin
        b = exp_q.pop_front();
        chk("out_s", 64'(bus.S_next), 64'(b.s));
        chk("out_path", 64'(bus.path_idx), 64'(b.p));
        chk("out_step", 64'(bus.step_idx), 64'(b.st));
        chk("out_last", 64'(bus.last), 64'(b.l));
      end
      got_s.push_back(longint'(bus.S_next));
      n_out++;
      if (bus.last) last_hs_cyc = cyc;
    end
    if (bus.done) begin
      if (done_cyc < 0) done_cyc = cyc;
      if (arm_start) bus.start = 1'b1;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic run(input int s0, input int drift, input int vol, input int zmode,
                     input int zconst, input bit bp, input int abort_after,
                     input bit pre_started);
    for (int i = 0; i < NP; i++) m_s[i] = longint'(s0);
    m_path = 0;
    m_step = 0;
    m_sat  = 1'b0;
    c_drift = longint'(drift);
    c_vol   = longint'(vol);
    n_in = 0;
    n_out = 0;
    last_hs_cyc = -1;
    done_cyc = -1;
    first_in_cyc = -1;
    first_out_cyc = -1;
    prev_stall = 1'b0;
    exp_q.delete();
    got_s.delete();
    bus.cfg_s0    = s0;
    bus.cfg_drift = drift;
    bus.cfg_vol   = vol;
    bus.valid_in  = 1'b0;
    bus.ready_in  = 1'b1;
    if (!pre_started) begin
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
    end
    chk("busy_after_start", 64'(bus.busy), 64'(1));
    chk("ready_after_start", 64'(bus.ready_out), 64'(1));
    chk("sat_clear_on_start", 64'(bus.sat_seen), 64'(0));
    chk("done_low_in_run", 64'(bus.done), 64'(0));
    for (int c = 0; c < 2000 && done_cyc < 0; c++) begin
      bus.valid_in = (n_in < NP*NS) && (!bp || ($urandom_range(0, 3) != 0));
      case (zmode)
        0:       zv = zconst;
        1:       zv = int'($urandom_range(0, 393216)) - 196608;
        default: zv = int'($urandom());
      endcase
      bus.z = zv;
      bus.ready_in = !bp || ($urandom_range(0, 9) >= 3);
      tick();
      if (abort_after > 0 && n_in >= abort_after) return;
    end
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    chk("done_seen", 64'(done_cyc >= 0), 64'(1));
    chk("beats_out", 64'(n_out), 64'(NP*NS));
    chk("beats_pending", 64'(exp_q.size()), 64'(0));
    chk("done_after_last", 64'(done_cyc), 64'(last_hs_cyc + 1));
    chk("sat_seen_model", 64'(bus.sat_seen), 64'(m_sat));
    chk("busy_idle", 64'(bus.busy), 64'(0));
    if (!bp) chk("latency", 64'(first_out_cyc - first_in_cyc), 64'(3));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid_out"}, 64'(bus.valid_out), 64'(0));
    chk({tag, "_ready_out"}, 64'(bus.ready_out), 64'(0));
    chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
    chk({tag, "_done"}, 64'(bus.done), 64'(0));
    chk({tag, "_last"}, 64'(bus.last), 64'(0));
    chk({tag, "_sat_seen"}, 64'(bus.sat_seen), 64'(0));
    chk({tag, "_S_next"}, 64'(bus.S_next), 64'(0));
    chk({tag, "_path_idx"}, 64'(bus.path_idx), 64'(0));
    chk({tag, "_step_idx"}, 64'(bus.step_idx), 64'(0));
  endtask

  task automatic chk_test1(input string tag);
    for (int i = 0; i < NP; i++) chk({tag, "_step0"}, 64'(got_s[i]), 64'(6619100));
    for (int i = NP; i < 2*NP; i++) chk({tag, "_step1"}, 64'(got_s[i]), 64'(6685255));
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.cfg_s0    = '0;
    bus.cfg_drift = '0;
    bus.cfg_vol   = '0;
    bus.valid_in  = 1'b0;
    bus.z         = '0;
    bus.ready_in  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Deterministic drift: 100.0 * (1 + 655/65536) per step
    run(6553600, 655, 13107, 0, 0, 1'b0, 0, 1'b0);
    chk_test1("drift");
    chk("drift_sat", 64'(bus.sat_seen), 64'(0));

    // Zero diffusion with arbitrary z
    run(6553600, 0, 0, 2, 0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 2*NP; i++) chk("zero_diff", 64'(got_s[i]), 64'(6553600));

    // Negative shock of -1.0
    run(6553600, 0, 13107, 0, -65536, 1'b0, 0, 1'b0);
    for (int i = 0; i < NP; i++) chk("neg_step0", 64'(got_s[i]), 64'(5242900));
    for (int i = NP; i < 2*NP; i++) chk("neg_step1", 64'(got_s[i]), 64'(4194336));
    chk("neg_sat", 64'(bus.sat_seen), 64'(0));

    // Floor clamp with a -8.0 shock
    run(6553600, 0, 13107, 0, -524288, 1'b0, 0, 1'b0);
    for (int i = 0; i < 2*NP; i++) chk("floor", 64'(got_s[i]), 64'(0));
    chk("floor_sat", 64'(bus.sat_seen), 64'(1));

    // Back-pressure with random valid_in / ready_in (next start clears sat_seen)
    run(6553600, 655, 13107, 1, 0, 1'b1, 0, 1'b0);
    arm_start = 1'b1;
    run(9830400, -300, 20000, 1, 0, 1'b1, 0, 1'b0);
    arm_start = 1'b0;

    // start held through the done cycle is taken one cycle later
    chk("start_on_done_ignored", 64'(bus.busy), 64'(0));
    bus.cfg_s0    = 6553600;
    bus.cfg_drift = 655;
    bus.cfg_vol   = 13107;
    tick();
    chk("start_after_done", 64'(bus.busy), 64'(1));
    bus.start = 1'b0;

    // Asynchronous reset after five accepted beats
    run(6553600, 655, 13107, 0, 0, 1'b0, 5, 1'b1);
    bus.valid_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("async_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_no_done", 64'(bus.done), 64'(0));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(6553600, 655, 13107, 0, 0, 1'b0, 0, 1'b0);
    chk_test1("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
